// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch 7-segment scanner: active-low segment
// patterns {g,f,e,d,c,b,a}, scan FSM states and decode helpers.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  // Non-decimal nibbles fall through to all segments off.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

  // A digit is a leading zero when it and every higher digit are zero;
  // the rightmost digit always stays visible.
  function automatic logic lzb_blank(input logic [15:0] digits, input logic [1:0] sel);
    case (sel)
      2'd1:    return (digits[15:4] == 12'h000);
      2'd2:    return (digits[15:8] == 8'h00);
      2'd3:    return (digits[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low 7-segment decoder with a forced-blank input.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : bcd_to_seg(bcd);
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed display scanner with blanking dead-time and
// frame-aligned value commit. Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh_clk,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        rf_prev;
  logic [15:0] act_digits;
  logic [15:0] pend_digits;
  logic [3:0]  act_dp;
  logic [3:0]  pend_dp;
  logic        pend_valid;

  logic        rf_edge;
  logic        advance;
  logic        wrap;
  logic        commit;
  logic        accept;
  logic [1:0]  next_sel;
  logic [15:0] next_digits;
  logic [3:0]  next_dp;
  logic [3:0]  nibble;
  logic        digit_blank;
  logic [6:0]  dec_seg;

  // The decoder looks at the value that will be active after this cycle, so
  // the first slot of a freshly committed frame already shows the new value.
  always_comb begin
    rf_edge     = refresh_clk & ~rf_prev;
    advance     = (state == DRIVE) && rf_edge;
    wrap        = advance && (digit_sel == 2'd3);
    commit      = wrap && pend_valid;
    accept      = upd_valid && upd_ready;
    next_sel    = advance ? digit_sel + 2'd1 : digit_sel;
    next_digits = commit ? pend_digits : act_digits;
    next_dp     = commit ? pend_dp : act_dp;
    nibble      = next_digits[{next_sel, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    digit_blank = lzb_blank(next_digits, next_sel);
`else
    digit_blank = 1'b0;
`endif
  end

  seg_decode u_decode (
    .bcd   (nibble),
    .blank (digit_blank),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= CNT_LOAD;
      digit_sel  <= 2'd0;
      rf_prev    <= 1'b1;
      an         <= 4'b1111;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      rf_prev    <= refresh_clk;
      frame_done <= wrap;
      case (state)
        // Edges that land here are simply dropped; the slot is not extended.
        BLANK: begin
          if (cnt == 8'd0) begin
            state <= DRIVE;
            an    <= ~(4'b0001 << digit_sel);
            seg   <= dec_seg;
            dp    <= ~next_dp[next_sel];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DRIVE: begin
          if (rf_edge) begin
            state     <= BLANK;
            cnt       <= CNT_LOAD;
            digit_sel <= next_sel;
            an        <= 4'b1111;
            seg       <= dec_seg;
            dp        <= ~next_dp[next_sel];
          end
        end
      endcase
    end
  end

  // Accept and commit never coincide: accepting needs an empty buffer,
  // committing needs a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_digits  <= 16'h0000;
      act_dp      <= 4'b0000;
      pend_digits <= 16'h0000;
      pend_dp     <= 4'b0000;
      pend_valid  <= 1'b0;
      upd_ready   <= 1'b1;
    end else if (commit) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      pend_valid <= 1'b0;
      upd_ready  <= 1'b1;
    end else if (accept) begin
      pend_digits <= upd_digits;
      pend_dp     <= upd_dp;
      pend_valid  <= 1'b1;
      upd_ready   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: expected digit drives are queued by
// the stimulus thread and popped by a monitor at each blank-to-drive transition.
module tb_seg_scan_controller;

  localparam int BLANK_CYCLES = 16;
  localparam int SLOT         = 1000;

  localparam logic [6:0] S0   = 7'h40;
  localparam logic [6:0] S1   = 7'h79;
  localparam logic [6:0] S2   = 7'h24;
  localparam logic [6:0] S3   = 7'h30;
  localparam logic [6:0] S4   = 7'h19;
  localparam logic [6:0] S5   = 7'h12;
  localparam logic [6:0] SOFF = 7'h7F;
`ifdef SEG_LZB_EN
  localparam logic [6:0] SZ   = 7'h7F;
`else
  localparam logic [6:0] SZ   = 7'h40;
`endif

  logic        clk;
  logic        rst_n;
  logic        refresh_clk;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;
  int frames     = 0;
  int blank_len  = 0;
  bit skip_len   = 1;
  logic [3:0]  prev_an = 4'hF;
  logic [13:0] exp_q[$];

  seg_scan_controller #(.BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .refresh_clk(refresh_clk),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_dp     (upd_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] sel, input logic [6:0] segv, input logic dpv);
    logic [3:0] anv;
    anv = ~(4'b0001 << sel);
    exp_q.push_back({anv, segv, dpv, sel});
  endtask

  // One refresh slot; optionally offers an update in the very edge cycle.
  task automatic applyStimulus(input bit upd_at_edge, input logic [15:0] d, input logic [3:0] m);
    @(negedge clk);
    refresh_clk = 1'b1;
    if (upd_at_edge) begin
      checkOutput("ready_at_wrap_edge", {31'd0, upd_ready}, 32'd1);
      upd_valid  = 1'b1;
      upd_digits = d;
      upd_dp     = m;
    end
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (SLOT / 2 - 1) @(negedge clk);
    refresh_clk = 1'b0;
    repeat (SLOT / 2) @(negedge clk);
  endtask

  // A slot whose second rising edge falls inside the blanking window.
  task automatic glitchSlot();
    @(negedge clk);
    refresh_clk = 1'b1;
    repeat (2) @(negedge clk);
    refresh_clk = 1'b0;
    repeat (2) @(negedge clk);
    refresh_clk = 1'b1;
    repeat (SLOT / 2) @(negedge clk);
    refresh_clk = 1'b0;
    repeat (SLOT / 2) @(negedge clk);
  endtask

  task automatic offerUpdate(input logic [15:0] d, input logic [3:0] m, input int hold);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_digits = d;
    upd_dp     = m;
    repeat (hold) @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic checkReset(input string name);
    checkOutput(name, {16'd0, an, seg, dp, digit_sel, frame_done, upd_ready},
                {16'd0, 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0, 1'b1});
  endtask

  // Monitor: every start of a digit drive pops one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      skip_len  = 1;
      blank_len = 0;
      prev_an   = 4'hF;
    end else begin
      if (an == 4'hF) begin
        blank_len++;
      end else if (prev_an == 4'hF) begin
        if (!skip_len) checkOutput("blank_len", blank_len, BLANK_CYCLES);
        skip_len = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_drive", {18'd0, an, seg, dp, digit_sel}, 32'd0);
        end else begin
          checkOutput($sformatf("drive_d%0d", digit_sel),
                      {18'd0, an, seg, dp, digit_sel}, {18'd0, exp_q.pop_front()});
        end
        blank_len = 0;
      end
      if (frame_done) begin
        checkOutput("frame_done_state", {26'd0, an, digit_sel}, {26'd0, 4'hF, 2'd0});
        frames++;
      end
      prev_an = an;
    end
  end

  initial begin
    rst_n       = 1'b0;
    refresh_clk = 1'b0;
    upd_valid   = 1'b0;
    upd_digits  = 16'h0000;
    upd_dp      = 4'b0000;
    repeat (3) @(negedge clk);
    checkReset("reset_values");
    pushExp(2'd0, S0, 1'b1);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Frame A: all zeros; an update arrives mid-frame and waits for the wrap
    pushExp(2'd1, SZ, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    offerUpdate(16'h1234, 4'b0100, 1);
    checkOutput("ready_low_after_accept", {31'd0, upd_ready}, 32'd0);
    offerUpdate(16'h9999, 4'b1111, 5);
    checkOutput("ready_low_second_offer", {31'd0, upd_ready}, 32'd0);
    pushExp(2'd2, SZ, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd3, SZ, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    checkOutput("ready_low_before_wrap", {31'd0, upd_ready}, 32'd0);
    pushExp(2'd0, S4, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    checkOutput("ready_high_after_commit", {31'd0, upd_ready}, 32'd1);

    // Frame B: 1234 shown; offer 00A5 in the exact wrap cycle
    pushExp(2'd1, S3, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd2, S2, 1'b0); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd3, S1, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd0, S4, 1'b1); applyStimulus(1, 16'h00A5, 4'b1000);
    checkOutput("ready_low_after_wrap_accept", {31'd0, upd_ready}, 32'd0);

    // Frame C: still 1234, then 00A5 commits
    pushExp(2'd1, S3, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd2, S2, 1'b0); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd3, S1, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd0, S5, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    checkOutput("ready_high_after_commit2", {31'd0, upd_ready}, 32'd1);

    // Frame D: 00A5, hex digit off, leading zeros depend on build, dp on digit 3
    pushExp(2'd1, SOFF, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd2, SZ, 1'b1);   applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd3, SZ, 1'b0);   applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd0, S5, 1'b1);   applyStimulus(0, 16'h0, 4'h0);

    // Frame E: reset during digit 2 with 8888 pending
    pushExp(2'd1, SOFF, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd2, SZ, 1'b1);   applyStimulus(0, 16'h0, 4'h0);
    offerUpdate(16'h8888, 4'b1111, 1);
    repeat (5) @(negedge clk);
    rst_n       = 1'b0;
    refresh_clk = 1'b1;
    #1;
    checkReset("reset_mid_frame");
    pushExp(2'd0, S0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    refresh_clk = 1'b0;
    repeat (20) @(negedge clk);

    // Post-reset frame: dropped glitch edge, pending 8888 must never appear
    pushExp(2'd1, SZ, 1'b1); glitchSlot();
    pushExp(2'd2, SZ, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd3, SZ, 1'b1); applyStimulus(0, 16'h0, 4'h0);
    pushExp(2'd0, S0, 1'b1); applyStimulus(0, 16'h0, 4'h0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("frame_count", frames, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Sequences the four-digit multiplexed 7-segment display of the stopwatch. It advances one digit per rising edge of the 10 kHz `refresh_clk` and inserts a fixed blanking dead-time between digits to suppress ghosting. It decodes BCD digits to segment patterns. New display values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never mixes two values. It sits between the stopwatch time counters and the board's anode/cathode pins.

## Interface
- `BLANK_CYCLES`, 16: dead-time in `clk` cycles with all anodes off after each digit switch. Legal range is 1..255. It must be shorter than one `refresh_clk` period.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `refresh_clk`  in  1  10 kHz square wave, synchronous to `clk`. Each rising edge ends the current digit slot.
- `upd_valid`  in  1  new display value offered.
- `upd_ready`  out  1  the pending buffer is empty and a value can be accepted.
- `upd_digits`  in  16  four BCD nibbles. `[3:0]` is digit 0 (rightmost) and `[15:12]` is digit 3.
- `upd_dp`  in  4  decimal-point enables, one per digit. 1 = lit.
- `an`  out  4  anode selects, active-low.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal-point cathode, active-low.
- `digit_sel`  out  2  index of the current digit slot.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Edge detect: `rf_prev` <= `refresh_clk` every cycle. An edge is `refresh_clk & ~rf_prev`.
- FSM states:
  - BLANK: `an`=4'b1111. A down-counter counts BLANK_CYCLES. When it reaches 0, go to DRIVE.
  - DRIVE: `an` has bit `digit_sel` low. On an edge, `digit_sel`++ (wraps 3→0), the counter loads BLANK_CYCLES-1, and the FSM goes to BLANK.
- Edges arriving during BLANK are dropped. The slot is not extended and no edge is queued.
- `seg` and `dp` update in the same cycle that BLANK is entered. They are taken from the active digit register selected by the new `digit_sel`.
- Decode: BCD 0–9 uses the standard patterns. Nibbles A–F produce all segments off, while `dp` is still honoured.
- Update path: the handshake fires when `upd_valid & upd_ready`. It loads a 1-deep pending buffer and clears `upd_ready` on the next cycle.
- Commit: at the 3→0 wrap, if the buffer is pending, it is copied to the active registers and the pending flag clears.
  - Digit 0 of the new frame uses the new value.
  - `upd_ready` returns high the cycle after the commit.
- Accept and wrap in the same cycle: only possible if the buffer was empty. The value is stored as pending and committed at the next wrap. There is no bypass.
- Async reset:
  - FSM = BLANK, counter = BLANK_CYCLES-1, `digit_sel`=0.
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_done`=0.
  - Active digits = 0, dp mask = 0, pending cleared, `upd_ready`=1.
  - `rf_prev`=1, so a `refresh_clk` that is high at reset release is not seen as an edge.
  - Reset asserted mid-frame forces these values immediately and discards any pending value.

## Timing
- Edge seen in cycle t → in cycle t+1, `an`=1111, the new `digit_sel` and `seg` are valid, and `frame_done` pulses if the scan wrapped.
- `an` drives the new digit in cycle t+1+BLANK_CYCLES.
- After reset release, digit 0 (showing "0") is driven after BLANK_CYCLES cycles, without waiting for an edge.
- All outputs are registered and there are no combinational paths from inputs to outputs. `upd_ready` is a register.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking is enabled.
  - Digits 3, 2 and 1 show all segments off when their nibble is 0 and every higher digit is also 0.
  - Digit 0 is never blanked.
  - `dp` of a blanked digit is still driven from the mask.
- `SEG_LZB_EN` undefined: every digit is decoded normally, and 0 shows "0".

## Structure
- Package `seg_pkg`: holds the 7-bit segment pattern constants for 0–9, `SEG_OFF`=7'h7F, and the FSM state enum (BLANK, DRIVE).
- Sub-module `seg_decode`: combinational BCD→segment decoder with a `blank` input. It is instantiated once on the selected digit.

## Test plan
- Reset, then an edge every 1000 cycles with BLANK_CYCLES=16 → `an` steps 1110→1101→1011→0111→1110, with 16 cycles of 1111 before each step. `frame_done` pulses once per 4 edges.
- Load `upd_digits`=16'h1234 and `upd_dp`=4'b0100 mid-frame → the display keeps the old value until the wrap. The next frame then shows digit 0 `seg`=pattern 4, …, digit 3 pattern 1, with `dp`=0 only on digit 2. `upd_ready` is low between accept and wrap+1.
- Second `upd_valid` while pending → not accepted (`upd_ready`=0). Only the first value is displayed.
- `upd_valid` in the exact wrap cycle with the buffer empty → committed one frame later, not immediately.
- `upd_digits`=16'h00A5: digit 1 is all segments off. Digits 3 and 2 are blanked with `SEG_LZB_EN` and show "0" without it.
- Assert `rst_n`=0 during DRIVE of digit 2 with an update pending → all outputs go to reset values immediately, `upd_ready`=1, and the pending value is never displayed.
